// File: rtl/esp32_spi_gamepad.sv
// ESP32 gamepad link: SPI-slave frame receiver, ESP32 strap pins and enable sequencer.
// Optional macro ESP32_PAD_TIMEOUT_EN adds a watchdog that clears buttons when frames stop.
module esp32_spi_gamepad #(
   parameter int RESET_CYCLES   = 1024,
   parameter int TIMEOUT_CYCLES = 2**22
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        user_reset,
   output logic        esp32_en,
   output logic        esp32_gpio0,
   output logic        esp32_gpio12,
   input  logic        spi_csn,
   input  logic        spi_clk,
   input  logic        spi_mosi,
   output logic [11:0] pad_btn
);

   localparam int EW = $clog2(RESET_CYCLES + 1);
   localparam logic [EW-1:0] EN_DONE = EW'(RESET_CYCLES);

   logic [EW-1:0] en_cnt, en_cnt_next;
   logic          clk_prev, csn_prev;
   logic          rise, csn_fall, csn_rise;
   logic [15:0]   shreg;
   logic [4:0]    bit_cnt, bit_cnt_base;
   logic          commit_pend;
   logic          wd_expire;

   assign esp32_gpio0  = 1'b1;
   assign esp32_gpio12 = 1'b0;

   always_comb begin
      en_cnt_next = en_cnt;
      if (user_reset)
         en_cnt_next = '0;
      else if (en_cnt != EN_DONE)
         en_cnt_next = en_cnt + EW'(1);
   end

   // esp32_en is registered from the next counter value so the pin never glitches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_cnt   <= '0;
         esp32_en <= 1'b0;
      end else begin
         en_cnt   <= en_cnt_next;
         esp32_en <= !user_reset && (en_cnt_next == EN_DONE);
      end
   end

   assign rise     = spi_clk & ~clk_prev;
   assign csn_fall = ~spi_csn & csn_prev;
   assign csn_rise = spi_csn & ~csn_prev;
   assign bit_cnt_base = csn_fall ? 5'd0 : bit_cnt;

   // A rise in the same cycle as csn_rise is dropped because spi_csn is already high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_prev    <= 1'b0;
         csn_prev    <= 1'b1;
         shreg       <= '0;
         bit_cnt     <= '0;
         commit_pend <= 1'b0;
      end else begin
         clk_prev    <= spi_clk;
         csn_prev    <= spi_csn;
         commit_pend <= csn_rise && (bit_cnt == 5'd16) && (shreg[15:12] == 4'hA);
         if (!spi_csn && rise) begin
            shreg   <= {shreg[14:0], spi_mosi};
            bit_cnt <= (bit_cnt_base == 5'd31) ? 5'd31 : bit_cnt_base + 5'd1;
         end else begin
            bit_cnt <= bit_cnt_base;
         end
      end
   end

`ifdef ESP32_PAD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_DONE = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] wd_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wd_cnt <= '0;
      else if (commit_pend && !user_reset)
         wd_cnt <= '0;
      else if (wd_cnt != TO_DONE)
         wd_cnt <= wd_cnt + TW'(1);
   end

   assign wd_expire = (wd_cnt == TO_DONE - TW'(1));
`else
   assign wd_expire = 1'b0;
`endif

   // user_reset outranks a commit, and a fresh commit outranks the watchdog
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pad_btn <= '0;
      else if (user_reset)
         pad_btn <= '0;
      else if (commit_pend)
         pad_btn <= shreg[11:0];
      else if (wd_expire)
         pad_btn <= '0;
   end

endmodule

// File: tb/tb_esp32_spi_gamepad.sv
// Scoreboard bench for esp32_spi_gamepad: stimulus queues expected pad/enable values
// tagged with a cycle number, and a negedge monitor pops and compares them.
module tb_esp32_spi_gamepad;

   localparam int RC = 20;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        user_reset;
   logic        esp32_en, esp32_gpio0, esp32_gpio12;
   logic        spi_csn, spi_clk, spi_mosi;
   logic [11:0] pad_btn;

   typedef struct {
      int          cyc;
      logic [11:0] pad;
      logic        en;
      bit          chk_en;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cycle = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   esp32_spi_gamepad #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .user_reset(user_reset),
      .esp32_en(esp32_en), .esp32_gpio0(esp32_gpio0), .esp32_gpio12(esp32_gpio12),
      .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .pad_btn(pad_btn)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle = cycle + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int cyc, input logic [11:0] pad, input logic en,
                       input bit chk_en, input string name);
      exp_t e;
      e.cyc = cyc; e.pad = pad; e.en = en; e.chk_en = chk_en; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic check_output(input exp_t e);
      n_cmp++;
      if (e.cyc != cycle) begin
         n_bad++;
         $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cycle, e.cyc);
      end
      n_cmp++;
      if (pad_btn !== e.pad) begin
         n_bad++;
         $display("[TB] FAIL %s pad_btn: got %h, expected %h (cycle %0d)", e.name, pad_btn, e.pad, cycle);
      end
      if (e.chk_en) begin
         n_cmp++;
         if (esp32_en !== e.en) begin
            n_bad++;
            $display("[TB] FAIL %s esp32_en: got %b, expected %b (cycle %0d)", e.name, esp32_en, e.en, cycle);
         end
      end
      n_cmp++;
      if (esp32_gpio0 !== 1'b1 || esp32_gpio12 !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL %s straps: got gpio0=%b gpio12=%b, expected 1/0", e.name, esp32_gpio0, esp32_gpio12);
      end
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
         mon_e = exp_q.pop_front();
         check_output(mon_e);
      end
   end

   task automatic drain();
      int budget;
      budget = 3000;
      while (exp_q.size() > 0 && budget > 0) begin
         tick();
         budget--;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL drain: %0d checks pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Sends n bits of v MSB-first; checks old value one cycle after csn rises, new value after two
   task automatic apply_stimulus(input logic [31:0] v, input int n, input logic [11:0] old_pad,
                                 input logic [11:0] new_pad, input logic en, input string name,
                                 output int commit_cyc);
      logic [31:0] bits;
      int c;
      bits = v;
      spi_csn = 1'b0;
      tick();
      for (int i = 0; i < n; i++) begin
         spi_mosi = bits[n-1-i];
         tick();
         spi_clk = 1'b1;
         tick();
         spi_clk = 1'b0;
      end
      tick();
      spi_csn = 1'b1;
      c = cycle;
      push(c + 1, old_pad, en, 1'b1, {name, "_hold"});
      push(c + 2, new_pad, en, 1'b1, name);
      commit_cyc = c + 2;
      tick();
   endtask

   initial begin
      int c, k;
      logic [11:0] to_pad;
      reset = 1'b0; user_reset = 1'b0;
      spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;

      push(3, 12'h000, 1'b0, 1'b1, "reset_state");
      repeat (5) tick();
      reset = 1'b1;
      c = cycle;
      push(c + RC - 1, 12'h000, 1'b0, 1'b1, "en_low_last");
      push(c + RC,     12'h000, 1'b1, 1'b1, "en_high");
      drain();

      apply_stimulus(32'hA801, 16, 12'h000, 12'h801, 1'b1, "frame_A801", k); drain();
      apply_stimulus(32'h2345, 15, 12'h801, 12'h801, 1'b1, "short_15", k); drain();
      apply_stimulus(32'h0A123, 17, 12'h801, 12'h801, 1'b1, "long_17", k); drain();
      apply_stimulus(32'h5FFF, 16, 12'h801, 12'h801, 1'b1, "bad_sync", k); drain();
      apply_stimulus(32'hA000, 16, 12'h801, 12'h000, 1'b1, "frame_A000", k); drain();
      apply_stimulus(32'hA0F0, 16, 12'h000, 12'h0F0, 1'b1, "frame_A0F0", k); drain();

      user_reset = 1'b1;
      c = cycle;
      push(c,     12'h0F0, 1'b1, 1'b1, "ur_before");
      push(c + 1, 12'h000, 1'b0, 1'b1, "ur_drop");
      repeat (10) tick();
      user_reset = 1'b0;
      c = cycle;
      push(c + RC - 1, 12'h000, 1'b0, 1'b1, "ur_en_low_last");
      push(c + RC,     12'h000, 1'b1, 1'b1, "ur_en_high");
      drain();

      user_reset = 1'b1;
      tick();
      apply_stimulus(32'hAFFF, 16, 12'h000, 12'h000, 1'b0, "blocked_commit", k);
      drain();
      user_reset = 1'b0;
      c = cycle;
      push(c + RC, 12'h000, 1'b1, 1'b1, "ur2_en_high");
      drain();

`ifdef ESP32_PAD_TIMEOUT_EN
      to_pad = 12'h000;
`else
      to_pad = 12'hFFF;
`endif
      apply_stimulus(32'hAFFF, 16, 12'h000, 12'hFFF, 1'b1, "frame_AFFF", k);
      push(k + TO - 1, 12'hFFF, 1'b1, 1'b1, "wd_before");
      push(k + TO,     to_pad,  1'b1, 1'b1, "wd_edge");
      push(k + TO + 50, to_pad, 1'b1, 1'b1, "wd_after");
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
